// File: rtl/adc_sim_pkg.sv
// Shared types and quantization helpers for the behavioural clocked ADC model.
// The quantizer returns a fixed-width bundle; callers keep the low BITS of the code.
package adc_sim_pkg;

    typedef enum logic {
        ADC_UNSIGNED = 1'b0,
        ADC_SIGNED   = 1'b1
    } adc_fmt_e;

    localparam int ADC_MAX_BITS = 24;

    typedef struct packed {
        logic                    ovfl_pos;
        logic                    ovfl_neg;
        logic [ADC_MAX_BITS-1:0] code;
    } adc_sample_t;

    function automatic real adc_lsb(input int bits, input real vpp);
        return vpp / real'(longint'(1) << bits);
    endfunction

    // Floor quantization with saturation. The comparisons stay in the real
    // domain so huge or infinite inputs never wrap through an integer cast.
    function automatic adc_sample_t adc_quantize(input real in, input int bits,
                                                 input real vpp, input adc_fmt_e fmt);
        adc_sample_t s;
        real         r;
        longint      min_raw;
        longint      max_raw;
        longint      raw;
        s       = '0;
        min_raw = -(longint'(1) << (bits - 1));
        max_raw = (longint'(1) << (bits - 1)) - 1;
        r       = $floor(in / adc_lsb(bits, vpp));
        // NaN fails every ordered compare, so it is caught by r != r.
        if ((r != r) || (r < real'(min_raw))) begin
            raw        = min_raw;
            s.ovfl_neg = 1'b1;
        end else if (r > real'(max_raw)) begin
            raw        = max_raw;
            s.ovfl_pos = 1'b1;
        end else begin
            raw = longint'(r);
        end
        if (fmt == ADC_UNSIGNED) begin
            raw = raw + (longint'(1) << (bits - 1));
        end
        s.code = ADC_MAX_BITS'(raw);
        return s;
    endfunction

endpackage

// File: rtl/adc_sim_if.sv
// Analog-in / digital-out bundle of the ADC model.
// master = the ADC itself, slave = the analog source and digital consumer side.
interface adc_sim_if #(
    parameter int BITS = 8
);
    real             in;
    logic [BITS-1:0] code;
    logic            ovfl_pos;
    logic            ovfl_neg;

    modport master (input in, output code, output ovfl_pos, output ovfl_neg);
    modport slave  (output in, input code, input ovfl_pos, input ovfl_neg);
endinterface

// File: rtl/adc_sim_pipe.sv
// Generic W-bit, N-stage delay line with asynchronous active-low clear.
// Stage 0 captures d; q is the last stage, so total latency is N edges.
module adc_sim_pipe #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_reg [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_stage
        logic [W-1:0] stage_next;

        if (gi == 0) begin : g_first
            assign stage_next = d;
        end else begin : g_rest
            assign stage_next = stage_reg[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_reg[gi] <= '0;
            end else begin
                stage_reg[gi] <= stage_next;
            end
        end
    end

    assign q = stage_reg[N-1];

endmodule

// File: rtl/adc_sim.sv
// Behavioural clocked ADC: floor-quantizes the real input every rising edge and
// delivers code plus clip flags after a PIPE-stage register chain.
module adc_sim #(
    parameter int    BITS = 8,
    parameter real   VPP  = 1.0,
    parameter int    PIPE = 5,
    parameter string TYPE = "unsigned"
) (
    input  logic       clk,
    input  logic       rst_n,
    adc_sim_if.master  bus
);
    import adc_sim_pkg::*;

    if ((TYPE != "unsigned") && (TYPE != "signed")) begin : g_bad_type
        $fatal(1, "adc_sim: TYPE must be \"unsigned\" or \"signed\"");
    end
    if ((BITS < 2) || (BITS > ADC_MAX_BITS)) begin : g_bad_bits
        $fatal(1, "adc_sim: BITS must be in 2..24");
    end
    if (PIPE < 1) begin : g_bad_pipe
        $fatal(1, "adc_sim: PIPE must be at least 1");
    end

    localparam adc_fmt_e FMT = (TYPE == "signed") ? ADC_SIGNED : ADC_UNSIGNED;

    adc_sample_t     sample_next;
    logic [BITS+1:0] pipe_d;
    logic [BITS+1:0] pipe_q;
    logic            unused_code_hi;

    // The quantizer feeds the first pipeline stage, which is the sampling register.
    assign sample_next    = adc_quantize(bus.in, BITS, VPP, FMT);
    assign pipe_d         = {sample_next.ovfl_pos, sample_next.ovfl_neg, sample_next.code[BITS-1:0]};
    assign unused_code_hi = ^sample_next.code;

    adc_sim_pipe #(
        .W (BITS + 2),
        .N (PIPE)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pipe_d),
        .q     (pipe_q)
    );

    assign bus.code     = pipe_q[BITS-1:0];
    assign bus.ovfl_neg = pipe_q[BITS];
    assign bus.ovfl_pos = pipe_q[BITS+1];

endmodule

// File: tb/tb_adc_sim.sv
// Scoreboard bench for adc_sim: one unsigned and one signed instance share the
// same input; expected outputs are queued at stimulus time and popped by a monitor.
module tb_adc_sim;

    localparam int BITS = 8;
    localparam int PIPE = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    adc_sim_if #(.BITS(BITS)) u_if ();
    adc_sim_if #(.BITS(BITS)) s_if ();

    adc_sim #(.BITS(BITS), .VPP(1.0), .PIPE(PIPE), .TYPE("unsigned")) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    adc_sim #(.BITS(BITS), .VPP(1.0), .PIPE(PIPE), .TYPE("signed")) s_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] code_u;
        logic [7:0] code_s;
        bit         pos;
        bit         neg;
        bit         ramp;
        bit         ramp_first;
    } exp_t;

    exp_t sb[$];

    function automatic void check(input string name, input int id, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s id=%0d: got %0d, expected %0d", name, id, act, exp);
    endfunction

    task automatic push(input int due, input int id, input logic [7:0] cu, input logic [7:0] cs,
                        input bit p, input bit n, input bit ramp, input bit first);
        exp_t e;
        e.due = due; e.id = id; e.code_u = cu; e.code_s = cs;
        e.pos = p; e.neg = n; e.ramp = ramp; e.ramp_first = first;
        sb.push_back(e);
    endtask

    // Called on a falling edge: input is sampled at the next rising edge.
    task automatic step(input real v, input int id, input logic [7:0] cu, input bit p, input bit n);
        u_if.in = v;
        s_if.in = v;
        push(cyc + PIPE, id, cu, cu ^ 8'h80, p, n, 1'b0, 1'b0);
        $display("step id=%0d in=%f exp_u=%0d exp_s=0x%02h pos=%0d neg=%0d", id, v, cu, cu ^ 8'h80, p, n);
        @(negedge clk);
    endtask

    task automatic check_zero(input int id);
        check("rst_code_u", id, int'(u_if.code), 0);
        check("rst_pos_u",  id, int'(u_if.ovfl_pos), 0);
        check("rst_neg_u",  id, int'(u_if.ovfl_neg), 0);
        check("rst_code_s", id, int'(s_if.code), 0);
        check("rst_pos_s",  id, int'(s_if.ovfl_pos), 0);
        check("rst_neg_s",  id, int'(s_if.ovfl_neg), 0);
        $display("reset check id=%0d", id);
    endtask

    // Called on a falling edge: stages not yet refilled must read as zeros.
    task automatic release_reset(input int id);
        rst_n = 1'b1;
        for (int k = 1; k < PIPE; k++) push(cyc + k, id + k, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    exp_t mon_e;
    int   prev_u;
    int   prev_s;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due < cyc) begin
                check("sb_late", mon_e.id, mon_e.due, cyc);
            end else if (!mon_e.ramp) begin
                check("code_u", mon_e.id, int'(u_if.code), int'(mon_e.code_u));
                check("pos_u",  mon_e.id, int'(u_if.ovfl_pos), int'(mon_e.pos));
                check("neg_u",  mon_e.id, int'(u_if.ovfl_neg), int'(mon_e.neg));
                check("code_s", mon_e.id, int'(s_if.code), int'(mon_e.code_s));
                check("pos_s",  mon_e.id, int'(s_if.ovfl_pos), int'(mon_e.pos));
                check("neg_s",  mon_e.id, int'(s_if.ovfl_neg), int'(mon_e.neg));
            end else begin
                if (mon_e.ramp_first) begin
                    prev_u = 0;
                    prev_s = -128;
                end
                check("ramp_pos_u", mon_e.id, int'(u_if.ovfl_pos), int'(mon_e.pos));
                check("ramp_neg_u", mon_e.id, int'(u_if.ovfl_neg), int'(mon_e.neg));
                check("ramp_pos_s", mon_e.id, int'(s_if.ovfl_pos), int'(mon_e.pos));
                check("ramp_neg_s", mon_e.id, int'(s_if.ovfl_neg), int'(mon_e.neg));
                check("ramp_mono_u", mon_e.id, int'(int'(u_if.code) >= prev_u), 1);
                check("ramp_mono_s", mon_e.id, int'(int'($signed(s_if.code)) >= prev_s), 1);
                if (mon_e.pos) check("ramp_clip_u", mon_e.id, int'(u_if.code), 255);
                if (mon_e.neg) check("ramp_clip_s", mon_e.id, int'($signed(s_if.code)), -128);
                prev_u = int'(u_if.code);
                prev_s = int'($signed(s_if.code));
            end
        end
    end

    real        vec_v [14] = '{0.0, -0.5, 0.49609375, 0.001, -0.001, 0.5, 2.5,
                               -0.6, -0.25, 0.25, -0.5001, -0.49609375, 0.2, -2.5};
    logic [7:0] vec_c [14] = '{8'd128, 8'd0, 8'd255, 8'd128, 8'd127, 8'd255, 8'd255,
                               8'd0, 8'd64, 8'd192, 8'd0, 8'd1, 8'd179, 8'd0};
    bit         vec_p [14] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    bit         vec_n [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    initial begin
        u_if.in = 0.0;
        s_if.in = 0.0;
        rst_n   = 1'b0;
        #1;
        check_zero(1);
        repeat (3) @(negedge clk);
        check_zero(2);
        release_reset(10);

        for (int i = 0; i < 14; i++) step(vec_v[i], 100 + i, vec_c[i], vec_p[i], vec_n[i]);

        // Latency: a step in the input shows up exactly PIPE-1 edges after sampling.
        repeat (4) step(0.0, 200, 8'd128, 1'b0, 1'b0);
        repeat (4) step(0.25, 201, 8'd192, 1'b0, 1'b0);
        repeat (3) step(0.5, 202, 8'd255, 1'b1, 1'b0);
        repeat (3) step(-0.75, 203, 8'd0, 1'b0, 1'b1);

        // Asynchronous reset between edges discards everything in flight.
        repeat (6) step(0.25, 300, 8'd192, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_zero(3);
        @(posedge clk);
        #1;
        check_zero(4);
        @(negedge clk);
        release_reset(310);
        repeat (6) step(0.25, 320, 8'd192, 1'b0, 1'b0);

        // Ramp -0.6 .. +0.6 in 1 mV steps; in = -0.5 at i=100, +0.5 at i=1100.
        for (int i = 0; i <= 1200; i++) begin
            u_if.in = real'(i - 600) / 1000.0;
            s_if.in = u_if.in;
            push(cyc + PIPE, 1000 + i, 8'd0, 8'd0, i >= 1100, i < 100, 1'b1, i == 0);
            if (i % 100 == 0) $display("ramp id=%0d in=%f", 1000 + i, u_if.in);
            @(negedge clk);
        end

        for (int k = 0; k < PIPE + 3 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) check("drain", 0, sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_sim.md
Name: adc_sim

Overview:
- Behavioural clocked ADC model for mixed-signal testbenches.
- Samples a real-valued analog input on each rising clock edge and quantizes it to a BITS-wide code (offset-binary or two's complement).
- Delays code and overflow flags through a PIPE-stage pipeline.
- Sits between an analog model (e.g. a circuit-current output) and digital DSP logic under test.

Parameters:
- BITS, 8, output code width (2..24).
- VPP, 1.0 (real), full-scale peak-to-peak input range in volts; input span is [-VPP/2, +VPP/2).
- PIPE, 5, total register stages including the sampling stage (>=1).
- TYPE, "unsigned", code format: "unsigned" = offset binary, "signed" = two's complement. Any other value is a fatal elaboration error.

Ports:
- clk  input  1  sampling clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in  input  real  analog input voltage.
- code  output  BITS  quantized sample.
- ovfl_pos  output  1  sample clipped at positive full scale.
- ovfl_neg  output  1  sample clipped at negative full scale.

Behaviour:
- Constant: LSB = VPP / 2^BITS (real).
- Quantization at each rising clk edge while rst_n=1: raw = floor(in / LSB), integer, computed in real/64-bit with no wrap.
- Signed limits: min = -2^(BITS-1), max = 2^(BITS-1)-1.
- If raw > max: clamp to max, ovfl_pos=1.
- If raw < min: clamp to min, ovfl_neg=1.
- Otherwise both flags are 0. The two flags are never both 1.
- Code mapping:
  - "signed": code = clamped raw, in two's complement.
  - "unsigned": code = clamped raw + 2^(BITS-1). Equivalently floor((in+VPP/2)/LSB), clamped to 0..2^BITS-1.
- Boundaries:
  - in = +VPP/2 exactly clips: max code, ovfl_pos=1.
  - in = -VPP/2 exactly is in range: min code, no flag.
  - Rounding is floor (toward -inf), never round-to-nearest.
- Latency: the sample taken at rising edge n appears on code/ovfl_* right after rising edge n+PIPE-1.
  - With PIPE=1 the outputs are the sampling register itself.
  - Code and flags travel together through the same stages.
- No enable/valid handshake: the model samples every edge and outputs update every edge.
- Reset:
  - rst_n low immediately (asynchronously) clears every pipeline stage: code = all zeros, ovfl_pos = ovfl_neg = 0, independent of TYPE.
  - Outputs hold those values while rst_n = 0.
  - After release, the first valid sample is taken at the first rising edge with rst_n=1 and appears PIPE-1 edges later. Stages not yet refilled still show zeros.
- Reset asserted mid-pipeline discards all in-flight samples.
- A non-finite input (NaN/±inf) is treated as out-of-range: NaN → negative clip with ovfl_neg; ±inf → matching clip.

Decomposition:
- Package adc_sim_pkg:
  - localparam-style functions adc_lsb(BITS,VPP) and adc_quantize(real in, BITS, VPP, signed_fmt), returning {code, ovfl_pos, ovfl_neg}.
  - A typedef adc_fmt_e {ADC_UNSIGNED, ADC_SIGNED} decoded from the TYPE string.
- One sub-module, adc_sim_pipe: generic W-bit, N-stage register delay line with async active-low clear. It carries the {ovfl_pos, ovfl_neg, code} bundle.
- Quantizer stays in the top as the stage-1 register input.

Test Plan (BITS=8, VPP=1.0, PIPE=5, LSB=0.00390625 unless noted):
- Unsigned mid/ends:
  - in=0.0 → code=128, flags 0.
  - in=-0.5 → code=0, flags 0.
  - in=0.49609375 → 255, flags 0.
  - in=0.001 → 128; in=-0.001 → 127.
- Clipping:
  - in=0.5 → code=255, ovfl_pos=1.
  - in=2.5 → 255, ovfl_pos=1.
  - in=-0.6 → code=0, ovfl_neg=1, ovfl_pos=0.
- Signed (TYPE="signed"):
  - in=-0.25 → code=0xC0 (-64).
  - in=0.5 → 0x7F with ovfl_pos=1.
  - in=-0.5 → 0x80, no flag.
- Latency: hold in=0.0, step to in=0.25 just before edge n → code stays 128 through edge n+3 and becomes 192 right after edge n+4. The ovfl transition follows the same timing.
- Reset mid-run: with code=192 streaming, pull rst_n low between edges → code=0 and flags 0 immediately, without a clock edge. Release → code stays 0 for 4 edges, then 192 after the 5th edge.
- Ramp sweep: ramp in from -0.6 to +0.6 in 0.001 V steps → code is monotonic non-decreasing, delayed by PIPE-1 edges. ovfl_neg is high exactly while in < -0.5; ovfl_pos is high exactly while in >= 0.5.
